// File: rtl/register_file_dumper_pkg.sv
// Shared debug-unit definitions: byte width, dumper FSM encoding and word/byte sizing helpers.
package register_file_dumper_pkg;

    localparam int DBG_NB_BYTE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    // Keep the byte counter at least one bit wide even for single-byte words.
    function automatic int byte_cnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/register_file_dumper.sv
// Streams every register-file word out as bytes (MSB first) over valid/ready; first byte valid
// two cycles after start, one idle bubble between words, holds byte/valid indefinitely while stalled.
module register_file_dumper
    import register_file_dumper_pkg::*;
#(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 2**NB_ADDR,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_read_addr,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int                 BPW       = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int                 NB_CNT    = byte_cnt_width(BPW);
    localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BPW - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;
    logic [NB_CNT-1:0]  cnt_q,   cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            // The word is snapshotted here; later writes to this register cannot leak into its bytes.
            ST_LOAD: begin
                shift_d = i_read_data;
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    if (cnt_q != LAST_BYTE) begin
                        shift_d = shift_q << NB_BYTE;
                        cnt_d   = cnt_q + NB_CNT'(1);
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + NB_ADDR'(1);
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_read_addr = addr_q;
    assign o_tx_valid  = (state_q == ST_SEND);
    assign o_tx_data   = o_tx_valid ? shift_q[NB_DATA-1 -: NB_BYTE] : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_register_file_dumper.sv
// Directed bench for register_file_dumper with a byte scoreboard fed from a register-file model.
module tb_register_file_dumper;

    localparam int NB_ADDR = 5;
    localparam int NB_DATA = 32;
    localparam int N_REGS  = 32;
    localparam int BPW     = 4;
    localparam int TOTAL   = N_REGS * BPW;
    localparam logic [31:0] NEW3 = 32'h3333_5555;
    localparam logic [31:0] NEW4 = 32'h4444_6666;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               rdy = 1'b0;
    logic [NB_ADDR-1:0] raddr;
    logic [NB_DATA-1:0] rdata;
    logic [7:0]         txd;
    logic               txv, busy, done;

    logic [31:0] regs [N_REGS];
    assign rdata = regs[raddr];

    always #5 clk = ~clk;

    register_file_dumper dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .o_read_addr(raddr),
        .i_read_data(rdata),
        .o_tx_data  (txd),
        .o_tx_valid (txv),
        .i_tx_ready (rdy),
        .o_busy     (busy),
        .o_done     (done)
    );

    int         ntests = 0;
    int         nfail = 0;
    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         bytes_seen = 0;
    int         done_seen = 0;
    int         first_vld_cyc = -1;
    int         rdy_mode = 0;
    bit         pending_done = 1'b0;
    bit         prev_stall = 1'b0;
    bit         poke_done = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < BPW; b++) exp_q.push_back(w[31-8*b -: 8]);
    endtask

    // One clock: drive inputs on the falling edge, then check outputs just after.
    task automatic tick(input bit st);
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        start = st | (poke_done & pending_done);
        rdy   = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        if (prev_stall) begin
            check("hold_vld", 32'(txv), 32'd1);
            check("hold_dat", 32'(txd), 32'(prev_data));
        end
        check("done", 32'(done), 32'(pending_done));
        if (pending_done) done_seen++;
        pending_done = 1'b0;
        if (txv && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (txv && rdy) begin
            check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", bytes_seen), 32'(txd), 32'(e));
                bytes_seen++;
                if (exp_q.size() == 0) pending_done = 1'b1;
            end
        end
        prev_stall = txv && !rdy;
        prev_data  = txd;
    endtask

    task automatic abort_dump();
        int d0;
        d0 = done_seen;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_vld", 32'(txv), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(raddr), 32'd0);
        check("abort_dat", 32'(txd), 32'd0);
        exp_q.delete();
        pending_done = 1'b0;
        prev_stall   = 1'b0;
        repeat (2) tick(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            check("post_abort_vld", 32'(txv), 32'd0);
        end
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
    endtask

    task automatic dump(input int mode, input int start_at, input bit pk,
                        input int write_at, input int abort_at);
        int         start_cyc;
        int         d0;
        bit         extra_done;
        bit         st;
        logic [31:0] w;
        rdy_mode      = mode;
        poke_done     = pk;
        first_vld_cyc = -1;
        bytes_seen    = 0;
        extra_done    = 1'b0;
        d0            = done_seen;
        for (int k = 0; k < N_REGS; k++) begin
            w = regs[k];
            if (write_at >= 0 && k == 4) w = NEW4;
            push_word(w);
        end
        tick(1'b1);
        start_cyc = cyc;
        for (int i = 0; i < 3000 && done_seen == d0; i++) begin
            st = 1'b0;
            if (start_at >= 0 && bytes_seen >= start_at && !extra_done) begin
                st         = 1'b1;
                extra_done = 1'b1;
            end
            if (write_at >= 0 && bytes_seen == write_at) begin
                regs[3] = NEW3;
                regs[4] = NEW4;
            end
            if (abort_at >= 0 && bytes_seen == abort_at) begin
                abort_dump();
                poke_done = 1'b0;
                return;
            end
            tick(st);
        end
        check("done_once", 32'(done_seen - d0), 32'd1);
        check("byte_count", 32'(bytes_seen), 32'(TOTAL));
        check("latency", 32'(first_vld_cyc - start_cyc), 32'd2);
        poke_done = 1'b0;
        tick(1'b0);
        check("busy_after", 32'(busy), 32'd0);
        repeat (5) tick(1'b0);
        check("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < N_REGS; k++) regs[k] = 32'hA0B0_C000 + 32'(k);
        #3;
        check("rst_addr", 32'(raddr), 32'd0);
        check("rst_dat", 32'(txd), 32'd0);
        check("rst_vld", 32'(txv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            check("idle_vld", 32'(txv), 32'd0);
        end

        dump(0, -1, 1'b0, -1, -1);   // ready always high
        dump(1, -1, 1'b0, -1, -1);   // random backpressure
        dump(0, 40, 1'b1, -1, -1);   // start during dump and in DONE
        dump(0, -1, 1'b0, -1, 17);   // reset mid-dump
        dump(1, -1, 1'b0, -1, -1);   // restart from reg 0
        dump(0, -1, 1'b0, 13, -1);   // snapshot vs later writes

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
